ps2_voice_tracker: RTL and testbench

Polyphonic note tracker that sits between the PS/2 keyboard receiver (`keyboard`) and the synth voice bank.
- Consumes scan bytes through the scan_ready/read handshake.
- Decodes make, break (F0) and extended (E0) sequences.
- Maps piano-row keys to notes with octave shift.
- Allocates notes to NUM_VOICES voice slots, each with a note number and a gate.

---
 rtl/ps2_voice_pkg.sv | 42 ++++
 rtl/ps2_ack_ctrl.sv | 32 +++
 rtl/ps2_voice_tracker.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_voice_tracker.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_voice_pkg.sv
// ps2_voice_pkg
// Shared definitions for the PS/2 voice tracker:
//   - scan code constants for the extended / break prefixes and octave keys
//   - piano-row key map returning {hit, index[3:0]}
//   - prefix decoder state enumeration
package ps2_voice_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_OCT_DN = 8'h1A;
   localparam logic [7:0] SC_OCT_UP = 8'h22;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } prefix_state_t;

   // Piano-row keys A W S E D F T G Y H U J K map to semitone indices 0..12.
   function automatic logic [4:0] key_map(input logic [7:0] code);
      logic [4:0] r;
      case (code)
         8'h1C:   r = {1'b1, 4'd0};
         8'h1D:   r = {1'b1, 4'd1};
         8'h1B:   r = {1'b1, 4'd2};
         8'h24:   r = {1'b1, 4'd3};
         8'h23:   r = {1'b1, 4'd4};
         8'h2B:   r = {1'b1, 4'd5};
         8'h2C:   r = {1'b1, 4'd6};
         8'h34:   r = {1'b1, 4'd7};
         8'h35:   r = {1'b1, 4'd8};
         8'h33:   r = {1'b1, 4'd9};
         8'h3C:   r = {1'b1, 4'd10};
         8'h3B:   r = {1'b1, 4'd11};
         8'h42:   r = {1'b1, 4'd12};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_ack_ctrl.sv
// ps2_ack_ctrl
// Turns the receiver's level "byte pending" flag into a single-cycle read
// acknowledge. The ack flag remembers that the current byte was taken so a
// held scan_ready is never read twice; it clears once scan_ready drops.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   scan_ready    receiver has a byte pending
//   read          one-cycle acknowledge, byte captured on this cycle
module ps2_ack_ctrl
(
   input  logic clock,
   input  logic reset,
   input  logic scan_ready,
   output logic read
);

   logic ack_flag;

   assign read = scan_ready & ~ack_flag & ~reset;

   // Set on the acknowledge cycle, cleared by the first idle cycle of scan_ready.
   always_ff @(posedge clock) begin
      if (reset) begin
         ack_flag <= 1'b0;
      end else if (read) begin
         ack_flag <= 1'b1;
      end else if (!scan_ready) begin
         ack_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_voice_tracker.sv
// ps2_voice_tracker
// Polyphonic note tracker between the PS/2 receiver and the voice bank.
// Decodes make / break / extended sequences, maps piano-row keys to notes
// with an octave offset, and allocates notes to NUM_VOICES voice slots.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   scan_ready     receiver has a byte pending
//   scan_code      pending byte, sampled on the read cycle
//   read           one-cycle acknowledge
//   voice_note     packed note per voice, voice 0 in LSBs
//   voice_gate     gate per voice
//   note_event     one-cycle pulse when a gate changes
//   event_voice    voice that changed (held until the next event)
//   event_on       1 = note on, 0 = note off (held until the next event)
//   octave         current signed octave offset
//   overflow       sticky: a press was dropped or a voice stolen
module ps2_voice_tracker
   import ps2_voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 7,
   parameter int BASE_NOTE  = 60,
   parameter int OCT_MIN    = -2,
   parameter int OCT_MAX    = 2,
   parameter int STEAL_MODE = 0,
   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
)
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         scan_ready,
   input  logic [7:0]                   scan_code,
   output logic                         read,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_gate,
   output logic                         note_event,
   output logic [VW-1:0]                event_voice,
   output logic                         event_on,
   output logic [3:0]                   octave,
   output logic                         overflow
);

   if (NUM_VOICES < 1 || NUM_VOICES > 16 || OCT_MIN > OCT_MAX || OCT_MIN < -8 ||
       OCT_MAX > 7 || STEAL_MODE < 0 || STEAL_MODE > 1 ||
       BASE_NOTE + 12*OCT_MIN < 0 || BASE_NOTE + 12*OCT_MAX + 12 >= (1 << NOTE_W)) begin : g_bad_params
      $error("ps2_voice_tracker: illegal parameter combination");
   end

   prefix_state_t     state_q, state_d;
   logic              press_req, release_req;
   logic [4:0]        key_lookup;
   logic              key_hit;
   logic [3:0]        key_idx;
   logic [3:0]        key_q  [NUM_VOICES];
   logic [NOTE_W-1:0] note_q [NUM_VOICES];
   logic signed [3:0] octave_q;
   logic [VW-1:0]     steal_ptr;
   logic              held_hit, free_found;
   logic [VW-1:0]     free_idx, held_idx;
   logic              assign_en, steal_now, drop_now, release_en;
   logic [VW-1:0]     assign_idx;
   logic [NOTE_W-1:0] note_calc;

   ps2_ack_ctrl u_ack (
      .clock      (clock),
      .reset      (reset),
      .scan_ready (scan_ready),
      .read       (read)
   );

   assign key_lookup = key_map(scan_code);
   assign key_hit    = key_lookup[4];
   assign key_idx    = key_lookup[3:0];

   // Signed arithmetic so negative octaves lower the note; truncated to NOTE_W.
   assign note_calc = NOTE_W'(BASE_NOTE + 12*int'(octave_q) + int'(key_idx));

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
      assign voice_note[g*NOTE_W +: NOTE_W] = note_q[g];
   end
   assign octave = octave_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Prefix decoder: only advances on the read cycle, and tells the voice
   // bank whether the captured byte is a press or a release.
   always_comb begin
      state_d     = state_q;
      press_req   = 1'b0;
      release_req = 1'b0;
      if (read) begin
         unique case (state_q)
            ST_IDLE: begin
               if (scan_code == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (scan_code == SC_BRK) begin
                  state_d = ST_BRK;
               end else begin
                  press_req = 1'b1;
               end
            end
            ST_EXT: begin
               state_d = (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_BRK: begin
               state_d     = ST_IDLE;
               release_req = (scan_code != SC_EXT) && (scan_code != SC_BRK);
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Descending scan so the lowest-numbered matches win. A key index can sit
   // in at most one gated voice, so held_idx is unambiguous.
   always_comb begin
      held_hit   = 1'b0;
      free_found = 1'b0;
      free_idx   = '0;
      held_idx   = '0;
      for (int v = NUM_VOICES-1; v >= 0; v--) begin
         if (!voice_gate[v]) begin
            free_found = 1'b1;
            free_idx   = VW'(v);
         end
         if (voice_gate[v] && key_q[v] == key_idx) begin
            held_hit = 1'b1;
            held_idx = VW'(v);
         end
      end
   end

   // Allocation decision: a repeat of a held key (typematic) is a no-op.
   always_comb begin
      assign_en  = 1'b0;
      assign_idx = free_idx;
      steal_now  = 1'b0;
      drop_now   = 1'b0;
      if (press_req && key_hit && !held_hit) begin
         if (free_found) begin
            assign_en = 1'b1;
         end else if (STEAL_MODE != 0) begin
            assign_en  = 1'b1;
            assign_idx = steal_ptr;
            steal_now  = 1'b1;
         end else begin
            drop_now = 1'b1;
         end
      end
   end

   assign release_en = release_req && key_hit && held_hit;

   // Voice bank, octave and event outputs. Release matches by key index so an
   // octave change between press and release does not strand a voice; the
   // note is kept after release for the envelope tail.
   always_ff @(posedge clock) begin
      if (reset) begin
         voice_gate  <= '0;
         octave_q    <= '0;
         steal_ptr   <= '0;
         overflow    <= 1'b0;
         note_event  <= 1'b0;
         event_voice <= '0;
         event_on    <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            key_q[v]  <= '0;
            note_q[v] <= '0;
         end
      end else begin
         note_event <= 1'b0;
         if (assign_en) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (VW'(v) == assign_idx) begin
                  key_q[v]      <= key_idx;
                  note_q[v]     <= note_calc;
                  voice_gate[v] <= 1'b1;
               end
            end
            note_event  <= 1'b1;
            event_voice <= assign_idx;
            event_on    <= 1'b1;
         end
         if (release_en) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (VW'(v) == held_idx) begin
                  voice_gate[v] <= 1'b0;
               end
            end
            note_event  <= 1'b1;
            event_voice <= held_idx;
            event_on    <= 1'b0;
         end
         if (steal_now || drop_now) begin
            overflow <= 1'b1;
         end
         if (steal_now) begin
            steal_ptr <= (steal_ptr == VW'(NUM_VOICES-1)) ? '0 : steal_ptr + 1'b1;
         end
         if (press_req && scan_code == SC_OCT_UP && int'(octave_q) < OCT_MAX) begin
            octave_q <= octave_q + 4'sd1;
         end
         if (press_req && scan_code == SC_OCT_DN && int'(octave_q) > OCT_MIN) begin
            octave_q <= octave_q - 4'sd1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_voice_tracker.sv
// tb_ps2_voice_tracker
// Drives two trackers (drop mode and steal mode) from the same byte stream.
// A reference model built from the key/voice rules predicts every note event
// into a per-DUT queue; a negedge monitor pops and compares on note_event.
module tb_ps2_voice_tracker;

   localparam int NV = 4;

   typedef struct {
      int voice;
      int on;
      int note;
   } ev_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        scan_ready = 1'b0;
   logic [7:0]  scan_code = 8'h00;

   logic        read0, read1;
   logic [27:0] vnote0, vnote1;
   logic [3:0]  vgate0, vgate1;
   logic        nev0, nev1;
   logic [1:0]  evv0, evv1;
   logic        evon0, evon1;
   logic [3:0]  oct0, oct1;
   logic        ovf0, ovf1;

   int n_checks = 0;
   int n_fail   = 0;

   ev_t        q0[$];
   ev_t        q1[$];
   logic [7:0] pfx[$];
   bit         mgate[2][NV];
   int         mkey[2][NV];
   int         mnote[2][NV];
   int         mptr[2];
   bit         movf[2];
   bit         evf[2];
   int         moct;
   int         key_codes[13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

   ps2_voice_tracker #(.NUM_VOICES(NV), .STEAL_MODE(0)) dut0 (
      .clock(clock), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
      .read(read0), .voice_note(vnote0), .voice_gate(vgate0), .note_event(nev0),
      .event_voice(evv0), .event_on(evon0), .octave(oct0), .overflow(ovf0));

   ps2_voice_tracker #(.NUM_VOICES(NV), .STEAL_MODE(1)) dut1 (
      .clock(clock), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
      .read(read1), .voice_note(vnote1), .voice_gate(vgate1), .note_event(nev1),
      .event_voice(evv1), .event_on(evon1), .octave(oct1), .overflow(ovf1));

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int keyIndex(input logic [7:0] code);
      for (int i = 0; i < 13; i++) begin
         if (key_codes[i] == int'(code)) return i;
      end
      return -1;
   endfunction

   task automatic pushEvent(input int m, input int v, input int on, input int note);
      ev_t e;
      e.voice = v;
      e.on    = on;
      e.note  = note;
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      evf[m] = 1'b1;
   endtask

   task automatic mdlReset();
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < NV; v++) begin
            mgate[m][v] = 1'b0;
            mkey[m][v]  = 0;
            mnote[m][v] = 0;
         end
         mptr[m] = 0;
         movf[m] = 1'b0;
      end
      moct = 0;
      pfx.delete();
      q0.delete();
      q1.delete();
   endtask

   task automatic mdlPress(input int m, input int idx);
      int note;
      int slot;
      note = (60 + 12*moct + idx) & 127;
      for (int v = 0; v < NV; v++) begin
         if (mgate[m][v] && mkey[m][v] == idx) return;
      end
      slot = -1;
      for (int v = NV-1; v >= 0; v--) begin
         if (!mgate[m][v]) slot = v;
      end
      if (slot < 0) begin
         movf[m] = 1'b1;
         if (m == 0) return;
         slot    = mptr[m];
         mptr[m] = (mptr[m] + 1) % NV;
      end
      mgate[m][slot] = 1'b1;
      mkey[m][slot]  = idx;
      mnote[m][slot] = note;
      pushEvent(m, slot, 1, note);
   endtask

   task automatic mdlRelease(input int m, input int idx);
      for (int v = 0; v < NV; v++) begin
         if (mgate[m][v] && mkey[m][v] == idx) begin
            mgate[m][v] = 1'b0;
            pushEvent(m, v, 0, mnote[m][v]);
            return;
         end
      end
   endtask

   // Byte-sequence rules expressed on the list of pending prefix bytes.
   task automatic mdlByte(input logic [7:0] code);
      int idx;
      idx    = keyIndex(code);
      evf[0] = 1'b0;
      evf[1] = 1'b0;
      if (pfx.size() == 0) begin
         if (code == 8'hE0 || code == 8'hF0) pfx.push_back(code);
         else if (code == 8'h22) begin
            if (moct < 2) moct++;
         end else if (code == 8'h1A) begin
            if (moct > -2) moct--;
         end else if (idx >= 0) begin
            mdlPress(0, idx);
            mdlPress(1, idx);
         end
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
         if (code == 8'hF0) pfx.push_back(code);
         else pfx.delete();
      end else if (pfx.size() == 1) begin
         pfx.delete();
         if (code != 8'hE0 && code != 8'hF0 && idx >= 0) begin
            mdlRelease(0, idx);
            mdlRelease(1, idx);
         end
      end else begin
         pfx.delete();
      end
   endtask

   // Presents one byte, holds scan_ready for 'hold' extra cycles, and checks
   // there is exactly one read and the event appears one cycle after it.
   task automatic applyStimulus(input logic [7:0] code, input int hold);
      int  reads;
      int  waited;
      bit  got;
      reads  = 0;
      waited = 0;
      got    = 1'b0;
      scan_code  = code;
      scan_ready = 1'b1;
      while (!got && waited < 20) begin
         @(negedge clock);
         if (read0) got = 1'b1;
         else waited++;
      end
      checkOutput("read acknowledge seen", int'(got), 1);
      if (!got) begin
         @(posedge clock); #1;
         scan_ready = 1'b0;
         return;
      end
      reads = 1;
      checkOutput("read lockstep", int'(read1), int'(read0));
      mdlByte(code);
      @(posedge clock); #1;
      if (hold == 0) scan_ready = 1'b0;
      @(negedge clock);
      if (read0) reads++;
      checkOutput("dut0 note_event latency", int'(nev0), int'(evf[0]));
      checkOutput("dut1 note_event latency", int'(nev1), int'(evf[1]));
      for (int i = 1; i < hold; i++) begin
         @(negedge clock);
         if (read0) reads++;
      end
      @(posedge clock); #1;
      scan_ready = 1'b0;
      @(posedge clock); #1;
      checkOutput("single read per byte", reads, 1);
   endtask

   task automatic doReset();
      @(posedge clock); #1;
      reset      = 1'b1;
      scan_ready = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("reset voice_note", int'(vnote0 | vnote1), 0);
      checkOutput("reset gates/events", int'({vgate0, vgate1, nev0, nev1, evon0, evon1, evv0, evv1}), 0);
      checkOutput("reset octave/overflow", int'({oct0, oct1, ovf0, ovf1}), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      mdlReset();
   endtask

   task automatic compareAll();
      for (int v = 0; v < NV; v++) begin
         checkOutput($sformatf("dut0 gate[%0d]", v), int'(vgate0[v]), int'(mgate[0][v]));
         checkOutput($sformatf("dut1 gate[%0d]", v), int'(vgate1[v]), int'(mgate[1][v]));
         checkOutput($sformatf("dut0 note[%0d]", v), int'(vnote0[v*7 +: 7]), mnote[0][v]);
         checkOutput($sformatf("dut1 note[%0d]", v), int'(vnote1[v*7 +: 7]), mnote[1][v]);
      end
      checkOutput("dut0 octave", int'($signed(oct0)), moct);
      checkOutput("dut1 octave", int'($signed(oct1)), moct);
      checkOutput("dut0 overflow", int'(ovf0), int'(movf[0]));
      checkOutput("dut1 overflow", int'(ovf1), int'(movf[1]));
   endtask

   task automatic popCheck(input int m, input int ev_v, input int ev_on, input logic [27:0] notes);
      ev_t e;
      int  pending;
      pending = (m == 0) ? q0.size() : q1.size();
      checkOutput($sformatf("dut%0d event expected", m), int'(pending > 0), 1);
      if (pending == 0) return;
      if (m == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      checkOutput($sformatf("dut%0d event_voice", m), ev_v, e.voice);
      checkOutput($sformatf("dut%0d event_on", m), ev_on, e.on);
      checkOutput($sformatf("dut%0d event note", m), int'(notes[ev_v*7 +: 7]), e.note);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (nev0) popCheck(0, int'(evv0), int'(evon0), vnote0);
         if (nev1) popCheck(1, int'(evv1), int'(evon1), vnote1);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] rc;
      int         r;
      mdlReset();
      doReset();

      // Held scan_ready gives one read and one on-event for voice 0.
      applyStimulus(8'h1C, 9);
      checkOutput("t1 voice0 note", int'(vnote0[6:0]), 60);
      checkOutput("t1 voice0 gate", int'(vgate0[0]), 1);
      checkOutput("t1 event_on/voice", int'({evon0, evv0}), 3'b100);

      // Typematic repeat is silent; release keeps the note.
      doReset();
      applyStimulus(8'h1C, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      checkOutput("t2 gate0 released", int'(vgate0[0]), 0);
      checkOutput("t2 note retained", int'(vnote0[6:0]), 60);
      checkOutput("t2 event_on off", int'(evon0), 0);

      // Octave saturation, then release across an octave change.
      doReset();
      repeat (3) applyStimulus(8'h22, 0);
      applyStimulus(8'h1C, 0);
      checkOutput("t3 octave saturates", int'($signed(oct0)), 2);
      checkOutput("t3 voice0 note", int'(vnote0[6:0]), 84);
      applyStimulus(8'h1A, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      checkOutput("t3 release after octave change", int'(vgate0[0]), 0);
      compareAll();

      // Five presses on four voices: drop vs steal.
      doReset();
      foreach (key_codes[i]) if (i < 5) applyStimulus(8'(key_codes[i]), 0);
      checkOutput("t4 drop notes", int'(vnote0), int'({7'd63, 7'd62, 7'd61, 7'd60}));
      checkOutput("t4 drop overflow", int'(ovf0), 1);
      checkOutput("t5 steal voice0 note", int'(vnote1[6:0]), 64);
      checkOutput("t5 steal overflow", int'(ovf1), 1);
      checkOutput("t5 steal event", int'({evon1, evv1}), 3'b100);
      // Second steal must take voice 1, confirming the pointer advanced.
      applyStimulus(8'h2B, 0);
      checkOutput("t5 second steal voice", int'(evv1), 1);
      compareAll();

      // Extended sequences are discarded; decoder returns to idle.
      doReset();
      applyStimulus(8'hE0, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'hE0, 0);
      applyStimulus(8'hF0, 0);
      applyStimulus(8'h1C, 0);
      applyStimulus(8'h15, 0);
      checkOutput("t6 no gates after extended", int'(vgate0), 0);
      applyStimulus(8'h1C, 0);
      checkOutput("t6 press after extended", int'(vgate0[0]), 1);

      // Reset in the middle of a break sequence.
      doReset();
      applyStimulus(8'hF0, 0);
      doReset();
      applyStimulus(8'h1C, 0);
      checkOutput("t6 press after mid-sequence reset", int'(vgate0[0]), 1);

      // Randomized byte stream against the reference model.
      doReset();
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45)      rc = 8'(key_codes[$urandom_range(0, 12)]);
         else if (r < 55) rc = ($urandom_range(0, 1) == 0) ? 8'h1A : 8'h22;
         else if (r < 80) rc = 8'hF0;
         else if (r < 88) rc = 8'hE0;
         else             rc = 8'($urandom_range(0, 255));
         applyStimulus(rc, int'($urandom_range(0, 2)));
         if (n % 20 == 19) compareAll();
      end
      compareAll();
      checkOutput("dut0 events drained", q0.size(), 0);
      checkOutput("dut1 events drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
